// File: rtl/spi_master_param_if.sv
// Command-side and SPI-side signal bundle for spi_master_param.
// The master modport is the SPI master's view; the slave modport is the front-end/off-chip view.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int CS_N   = 4
);
    localparam int CS_W = (CS_N > 1) ? $clog2(CS_N) : 1;

    logic              Tx_En;
    logic [DATA_W-1:0] Tx_DATA;
    logic [CS_W-1:0]   CS_SEL;
    logic              CPOL;
    logic              CPHA;
    logic              LSB_FIRST;
    logic              MISO;
    logic              MOSI;
    logic              SCK;
    logic [CS_N-1:0]   CSo;
    logic [DATA_W-1:0] Rx_DATA;
    logic              BUSY;
    logic              TC;

    modport master (
        input  Tx_En, Tx_DATA, CS_SEL, CPOL, CPHA, LSB_FIRST, MISO,
        output MOSI, SCK, CSo, Rx_DATA, BUSY, TC
    );

    modport slave (
        output Tx_En, Tx_DATA, CS_SEL, CPOL, CPHA, LSB_FIRST, MISO,
        input  MOSI, SCK, CSo, Rx_DATA, BUSY, TC
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, SCK divider and chip selects, all CPOL/CPHA modes.
// Everything runs on CLK; SCK is a registered output toggled on half-period ticks.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CS_N    = 4,
    parameter int CLK_DIV = 4
) (
    input  logic               CLK,
    input  logic               RST_,
    spi_master_param_if.master bus
);
    localparam int CS_W   = (CS_N > 1) ? $clog2(CS_N) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_data;
    logic [CS_N-1:0]   cso;
    logic              cpha;
    logic              lsb_first;
    logic              sck;
    logic              mosi;
    logic              tc;

    logic start, tick, do_edge, leading, last_edge, do_sample, do_shift, done;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    // An out-of-range index matches no select line, so the frame runs with every CSo high.
    function automatic logic [CS_N-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [CS_N-1:0] d;
        for (int i = 0; i < CS_N; i++) begin
            d[i] = (sel != CS_W'(i));
        end
        return d;
    endfunction

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = TRAIL;
            TRAIL:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge k is numbered edge_cnt+1; odd k is the leading edge.
    always_comb begin
        start     = 1'b0;
        do_edge   = 1'b0;
        done      = 1'b0;
        tick      = (div_cnt == DIV_LAST);
        leading   = ~edge_cnt[0];
        last_edge = (edge_cnt == EDGE_LAST);
        case (state)
            IDLE:       start   = bus.Tx_En;
            LEAD, XFER: do_edge = tick;
            TRAIL:      done    = tick;
            default:    ;
        endcase
        do_sample = do_edge && (leading ^ cpha);
        do_shift  = do_edge && (cpha ? leading : (!leading && !last_edge));
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            cso       <= '1;
            cpha      <= 1'b0;
            lsb_first <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (state == IDLE) begin
                div_cnt  <= '0;
                edge_cnt <= '0;
                sck      <= bus.CPOL;
                mosi     <= 1'b0;
                cso      <= '1;
                if (start) begin
                    cpha      <= bus.CPHA;
                    lsb_first <= bus.LSB_FIRST;
                    cso       <= cs_decode(bus.CS_SEL);
                    rx_sh     <= '0;
                    if (!bus.CPHA) begin
                        mosi  <= first_bit(bus.Tx_DATA, bus.LSB_FIRST);
                        tx_sh <= shift_out(bus.Tx_DATA, bus.LSB_FIRST);
                    end else begin
                        tx_sh <= bus.Tx_DATA;
                    end
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (do_edge) begin
                    sck      <= ~sck;
                    edge_cnt <= edge_cnt + 1'b1;
                end
                if (do_shift) begin
                    mosi  <= first_bit(tx_sh, lsb_first);
                    tx_sh <= shift_out(tx_sh, lsb_first);
                end
                if (do_sample) begin
                    rx_sh <= lsb_first ? {bus.MISO, rx_sh[DATA_W-1:1]}
                                       : {rx_sh[DATA_W-2:0], bus.MISO};
                end
                if (done) begin
                    cso     <= '1;
                    mosi    <= 1'b0;
                    tc      <= 1'b1;
                    rx_data <= rx_sh;
                end
            end
        end
    end

    assign bus.MOSI    = mosi;
    assign bus.SCK     = sck;
    assign bus.CSo     = cso;
    assign bus.Rx_DATA = rx_data;
    assign bus.BUSY    = (state != IDLE);
    assign bus.TC      = tc;
endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench: an 8-bit/4-CS/div-4 master and a 16-bit/1-CS/div-1 master, checked
// cycle by cycle against a timing model and a behavioural SPI slave.
module tb_spi_master_param;
    logic CLK = 1'b0;
    logic RST_;
    always #5 CLK = ~CLK;

    spi_master_param_if #(.DATA_W(8),  .CS_N(4)) if0 ();
    spi_master_param_if #(.DATA_W(16), .CS_N(1)) if1 ();

    spi_master_param #(.DATA_W(8), .CS_N(4), .CLK_DIV(4)) u0 (.CLK(CLK), .RST_(RST_), .bus(if0));
    spi_master_param #(.DATA_W(16), .CS_N(1), .CLK_DIV(1)) u1 (.CLK(CLK), .RST_(RST_), .bus(if1));

    logic        dut_sel  = 1'b0;
    logic        tx_en    = 1'b0;
    logic [15:0] tx_data  = 16'h0;
    logic [1:0]  cs_sel   = 2'd0;
    logic        cpol     = 1'b0;
    logic        cpha     = 1'b0;
    logic        lsb      = 1'b0;
    logic        loop0    = 1'b0;
    logic        miso_drv = 1'b0;

    int checks = 0;
    int errors = 0;

    assign if0.Tx_En     = tx_en & ~dut_sel;
    assign if0.Tx_DATA   = tx_data[7:0];
    assign if0.CS_SEL    = cs_sel;
    assign if0.CPOL      = cpol;
    assign if0.CPHA      = cpha;
    assign if0.LSB_FIRST = lsb;
    assign if0.MISO      = loop0 ? if0.MOSI : miso_drv;

    assign if1.Tx_En     = tx_en & dut_sel;
    assign if1.Tx_DATA   = tx_data;
    assign if1.CS_SEL    = cs_sel[0];
    assign if1.CPOL      = cpol;
    assign if1.CPHA      = cpha;
    assign if1.LSB_FIRST = lsb;
    assign if1.MISO      = if1.MOSI;

    logic        o_mosi, o_sck, o_busy, o_tc;
    logic [3:0]  o_cso;
    logic [15:0] o_rx;
    assign o_mosi = dut_sel ? if1.MOSI : if0.MOSI;
    assign o_sck  = dut_sel ? if1.SCK  : if0.SCK;
    assign o_busy = dut_sel ? if1.BUSY : if0.BUSY;
    assign o_tc   = dut_sel ? if1.TC   : if0.TC;
    assign o_cso  = dut_sel ? {3'b111, if1.CSo} : if0.CSo;
    assign o_rx   = dut_sel ? if1.Rx_DATA : {8'h00, if0.Rx_DATA};

    // One frame from the E0 edge to TC, observed every negedge; the slave model shifts slave_word out.
    task automatic run_frame(input logic which, input logic [15:0] data, input logic [1:0] sel,
                             input logic pol, input logic pha, input logic lsbf,
                             input logic [15:0] slave_word, input logic lb,
                             input bit mid_pulse, input bit chain);
        int dw, div, frame_end, edges, n, j, idx;
        logic [15:0] exp_rx, slave_rx;
        logic [3:0]  exp_cso;
        logic        prev_sck, exp_sck, exp_mosi;
        dw = which ? 16 : 8;
        div = which ? 1 : 4;
        frame_end = (2 * dw + 1) * div;
        if (dw == 8) begin
            data[15:8] = 8'h00;
            slave_word[15:8] = 8'h00;
        end
        exp_cso = 4'hF;
        if (int'(sel) < (which ? 1 : 4)) exp_cso[sel] = 1'b0;
        exp_rx = lb ? data : slave_word;
        dut_sel = which; tx_data = data; cs_sel = sel;
        cpol = pol; cpha = pha; lsb = lsbf; loop0 = lb; miso_drv = 1'b0; tx_en = 1'b1;
        @(posedge CLK);
        edges = 0; prev_sck = pol; slave_rx = 16'h0;
        for (int c = 0; c <= frame_end; c++) begin
            @(negedge CLK);
            if (c == 0) tx_en = 1'b0;
            if (mid_pulse && c == 20) tx_en = 1'b1;
            if (mid_pulse && c == 21) tx_en = 1'b0;
            if (chain && c == frame_end - 5) tx_en = 1'b1;
            if (c == 10) begin
                tx_data = 16'($urandom); cs_sel = 2'($urandom);
                cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
            end
            if (o_sck !== prev_sck) begin
                edges++;
                prev_sck = o_sck;
                if ((pha == 1'b0) == (edges % 2 == 1)) begin
                    j = (pha ? edges / 2 : (edges + 1) / 2) - 1;
                    if (j >= 0 && j < dw) slave_rx[lsbf ? j : dw - 1 - j] = o_mosi;
                end
            end
            idx = pha ? (edges + 1) / 2 - 1 : edges / 2;
            miso_drv = (idx >= 0 && idx < dw) ? slave_word[lsbf ? idx : dw - 1 - idx] : 1'b0;
            n = c / div;
            if (n > 2 * dw) n = 2 * dw;
            exp_sck = pol ^ n[0];
            checks++;
            if (o_sck !== exp_sck) begin
                errors++; $display("[TB] FAIL sck c=%0d: got %b expected %b", c, o_sck, exp_sck);
            end
            if (c < frame_end) begin
                checks++;
                if (o_cso !== exp_cso || o_busy !== 1'b1 || o_tc !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL in_frame c=%0d: got cso=%b busy=%b tc=%b expected cso=%b busy=1 tc=0",
                             c, o_cso, o_busy, o_tc, exp_cso);
                end
                if (!pha || c >= div) begin
                    j = pha ? (c - div) / (2 * div) : c / (2 * div);
                    if (j > dw - 1) j = dw - 1;
                    exp_mosi = data[lsbf ? j : dw - 1 - j];
                    checks++;
                    if (o_mosi !== exp_mosi) begin
                        errors++; $display("[TB] FAIL mosi c=%0d: got %b expected %b", c, o_mosi, exp_mosi);
                    end
                end
            end else begin
                checks++;
                if (o_tc !== 1'b1 || o_busy !== 1'b0 || o_cso !== 4'hF || o_mosi !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL frame_end: got tc=%b busy=%b cso=%b mosi=%b expected tc=1 busy=0 cso=1111 mosi=0",
                             o_tc, o_busy, o_cso, o_mosi);
                end
                checks++;
                if (o_rx !== exp_rx) begin
                    errors++; $display("[TB] FAIL rx_data: got %h expected %h", o_rx, exp_rx);
                end
                checks++;
                if (edges != 2 * dw || slave_rx !== data) begin
                    errors++;
                    $display("[TB] FAIL slave_view: got edges=%0d word=%h expected edges=%0d word=%h",
                             edges, slave_rx, 2 * dw, data);
                end
            end
        end
        if (!chain) begin
            @(negedge CLK);
            checks++;
            if (o_tc !== 1'b0 || o_rx !== exp_rx || o_sck !== cpol || o_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL after_tc: got tc=%b rx=%h sck=%b busy=%b expected tc=0 rx=%h sck=%b busy=0",
                         o_tc, o_rx, o_sck, o_busy, exp_rx, cpol);
            end
        end
    endtask

    task automatic test_reset();
        RST_ = 1'b0;
        #12;
        checks++;
        if (if0.MOSI !== 1'b0 || if0.SCK !== 1'b0 || if0.CSo !== 4'hF || if0.Rx_DATA !== 8'h00 ||
            if0.BUSY !== 1'b0 || if0.TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_u0: got mosi=%b sck=%b cso=%b rx=%h busy=%b tc=%b expected 0 0 1111 00 0 0",
                     if0.MOSI, if0.SCK, if0.CSo, if0.Rx_DATA, if0.BUSY, if0.TC);
        end
        checks++;
        if (if1.MOSI !== 1'b0 || if1.SCK !== 1'b0 || if1.CSo !== 1'b1 || if1.Rx_DATA !== 16'h0 ||
            if1.BUSY !== 1'b0 || if1.TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_u1: got mosi=%b sck=%b cso=%b rx=%h busy=%b tc=%b expected 0 0 1 0000 0 0",
                     if1.MOSI, if1.SCK, if1.CSo, if1.Rx_DATA, if1.BUSY, if1.TC);
        end
        @(negedge CLK);
        RST_ = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mode0_loopback();
        run_frame(1'b0, 16'h00A5, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mode3_slave();
        run_frame(1'b0, 16'h00C3, 2'd0, 1'b1, 1'b1, 1'b0, 16'h003C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lsb_first();
        run_frame(1'b0, 16'h0001, 2'd2, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 16'h0096, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_frame(1'b0, 16'h0069, 2'd3, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        dut_sel = 1'b0; tx_data = 16'h005A; cs_sel = 2'd1;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; loop0 = 1'b1; tx_en = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        tx_en = 1'b0;
        repeat (28) @(posedge CLK);
        #1 RST_ = 1'b0;
        #1;
        checks++;
        if (if0.SCK !== 1'b0 || if0.CSo !== 4'hF || if0.BUSY !== 1'b0 || if0.Rx_DATA !== 8'h00 ||
            if0.MOSI !== 1'b0 || if0.TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got sck=%b cso=%b busy=%b rx=%h mosi=%b tc=%b expected 0 1111 0 00 0 0",
                     if0.SCK, if0.CSo, if0.BUSY, if0.Rx_DATA, if0.MOSI, if0.TC);
        end
        @(negedge CLK);
        RST_ = 1'b1;
        @(negedge CLK);
        run_frame(1'b0, 16'h00E7, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wide();
        run_frame(1'b1, 16'hBEEF, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_frame(1'b1, 16'h1234, 2'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 10; i++) begin
            r = $urandom;
            run_frame(1'b0, {8'h00, r[7:0]}, r[9:8], r[10], r[11], r[12],
                      {8'h00, r[23:16]}, r[13], 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            run_frame(1'b1, r[15:0], {1'b0, r[16]}, r[17], r[18], r[19], 16'h0000, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_lsb_first();
        test_back_to_back();
        test_mid_reset();
        test_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
